line_follow_sequencer: RTL and testbench

Motion sequencer for the line-follow robot: samples the three line sensors, runs the follow/turn/search state machine and drives direction and PWM enables for both motors. Sits between the sensor inputs and the motor driver pins. It replaces free-running timed direction toggling with sensor-driven sequencing and ms-based timeouts.

---
 rtl/line_follow_sequencer.sv | 175 +++++++++++++++++
 tb/tb_line_follow_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/line_follow_sequencer.sv
// Line-follow motion sequencer: synchronises the three line sensors, runs the
// follow/turn/search/halt state machine and drives motor direction and PWM enables.
module line_follow_sequencer #(
  parameter int TICK_DIV   = 50000,
  parameter int PWM_PERIOD = 1000,
  parameter int DUTY_FAST  = 800,
  parameter int DUTY_SLOW  = 300,
  parameter int LOST_MS    = 200,
  parameter int SEARCH_MS  = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [2:0] sensors,
  output logic       dirL,
  output logic       dirR,
  output logic       pwmL,
  output logic       pwmR,
  output logic [2:0] state
);

  localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MS_MAX = (LOST_MS > SEARCH_MS) ? LOST_MS : SEARCH_MS;
  localparam int MS_W   = $clog2(MS_MAX + 1);
  localparam int CNT_W  = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
  localparam int DUTY_W = $clog2(PWM_PERIOD + 1);

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [MS_W-1:0]   MS_LOST   = MS_W'(LOST_MS);
  localparam logic [MS_W-1:0]   MS_SRCH_L = MS_W'(SEARCH_MS - 1);
  localparam logic [MS_W-1:0]   MS_SAT    = {MS_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PWM_PERIOD - 1);
  localparam logic [DUTY_W-1:0] D_FAST    = DUTY_W'(DUTY_FAST);
  localparam logic [DUTY_W-1:0] D_SLOW    = DUTY_W'(DUTY_SLOW);
  localparam logic [DUTY_W-1:0] D_OFF     = '0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FWD    = 3'd1,
    LEFT   = 3'd2,
    RIGHT  = 3'd3,
    SEARCH = 3'd4,
    HALT   = 3'd5
  } state_t;

  state_t            st, st_nx;
  logic [2:0]        sync_p0, sync_p1;
  logic [PRE_W-1:0]  pre;
  logic [MS_W-1:0]   ms;
  logic              last_turn;
  logic [CNT_W-1:0]  cnt;
  logic [DUTY_W-1:0] dutyL, dutyR, dutyL_nx, dutyR_nx;
  logic              dirL_nx, dirR_nx;
  logic              lost_st, pre_wrap, lost_done, search_done, count_en;

  // 101 is ambiguous while following, but in SEARCH it means the line is underneath
  function automatic state_t decode(input logic [2:0] s, input state_t cur);
    case (s)
      3'b010, 3'b111: decode = FWD;
      3'b100, 3'b110: decode = LEFT;
      3'b001, 3'b011: decode = RIGHT;
      3'b101:         decode = (cur == SEARCH) ? FWD : cur;
      default:        decode = cur;
    endcase
  endfunction

  // Stage p0/p1: two-flop sensor synchroniser
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= 3'b000;
      sync_p1 <= 3'b000;
    end else begin
      sync_p0 <= sensors;
      sync_p1 <= sync_p0;
    end
  end

  // Lost timeout compares the registered count (one edge late); the search
  // timeout fires on the edge that would complete SEARCH_MS.
  always_comb begin
    lost_st     = (st == FWD) || (st == LEFT) || (st == RIGHT);
    pre_wrap    = (pre == PRE_LAST);
    lost_done   = (ms == MS_LOST);
    search_done = pre_wrap && (ms == MS_SRCH_L);
    st_nx       = st;
    if (!enable) begin
      st_nx = IDLE;
    end else begin
      case (st)
        IDLE:             st_nx = FWD;
        FWD, LEFT, RIGHT: begin
          if (sync_p1 != 3'b000) st_nx = decode(sync_p1, st);
          else if (lost_done)    st_nx = SEARCH;
        end
        SEARCH: begin
          if (sync_p1 != 3'b000) st_nx = decode(sync_p1, st);
          else if (search_done)  st_nx = HALT;
        end
        HALT:    st_nx = HALT;
        default: st_nx = IDLE;
      endcase
    end
    count_en = (st_nx == st) && ((lost_st && (sync_p1 == 3'b000)) || (st == SEARCH));
  end

  always_comb begin
    dirL_nx  = 1'b1;
    dirR_nx  = 1'b1;
    dutyL_nx = D_OFF;
    dutyR_nx = D_OFF;
    case (st_nx)
      FWD:   begin dutyL_nx = D_FAST; dutyR_nx = D_FAST; end
      LEFT:  begin dutyL_nx = D_SLOW; dutyR_nx = D_FAST; end
      RIGHT: begin dutyL_nx = D_FAST; dutyR_nx = D_SLOW; end
      SEARCH: begin
        dirL_nx  = last_turn;
        dirR_nx  = ~last_turn;
        dutyL_nx = D_SLOW;
        dutyR_nx = D_SLOW;
      end
      default: ;
    endcase
  end

  // Stage p2: state, timers, last turn and registered motor settings
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st        <= IDLE;
      pre       <= '0;
      ms        <= '0;
      last_turn <= 1'b0;
      dirL      <= 1'b1;
      dirR      <= 1'b1;
      dutyL     <= D_OFF;
      dutyR     <= D_OFF;
    end else begin
      st    <= st_nx;
      dirL  <= dirL_nx;
      dirR  <= dirR_nx;
      dutyL <= dutyL_nx;
      dutyR <= dutyR_nx;
      if (count_en) begin
        if (pre_wrap) begin
          pre <= '0;
          if (ms != MS_SAT) ms <= ms + 1'b1;
        end else begin
          pre <= pre + 1'b1;
        end
      end else begin
        pre <= '0;
        ms  <= '0;
      end
      if (st_nx != st) begin
        if (st_nx == LEFT)  last_turn <= 1'b0;
        if (st_nx == RIGHT) last_turn <= 1'b1;
      end
    end
  end

  // PWM: free-running period counter, phase unaffected by state changes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      pwmL <= 1'b0;
      pwmR <= 1'b0;
    end else begin
      cnt  <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      pwmL <= (DUTY_W'(cnt) < dutyL);
      pwmR <= (DUTY_W'(cnt) < dutyR);
    end
  end

  assign state = st;

endmodule

// File: tb/tb_line_follow_sequencer.sv
// Scoreboard bench for line_follow_sequencer with small timing parameters.
module tb_line_follow_sequencer;

  localparam int TICK_DIV   = 10;
  localparam int PWM_PERIOD = 10;
  localparam int DUTY_FAST  = 8;
  localparam int DUTY_SLOW  = 3;
  localparam int LOST_MS    = 4;
  localparam int SEARCH_MS  = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [2:0] sensors;
  logic       dirL, dirR, pwmL, pwmR;
  logic [2:0] state;

  always #5 clk = ~clk;

  line_follow_sequencer #(
    .TICK_DIV(TICK_DIV), .PWM_PERIOD(PWM_PERIOD), .DUTY_FAST(DUTY_FAST),
    .DUTY_SLOW(DUTY_SLOW), .LOST_MS(LOST_MS), .SEARCH_MS(SEARCH_MS)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .sensors(sensors),
    .dirL(dirL), .dirR(dirR), .pwmL(pwmL), .pwmR(pwmR), .state(state)
  );

  typedef struct {
    string tag;
    int    exp;
  } sb_t;

  sb_t sbq[$];
  int  n_cmp = 0;
  int  n_mis = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_val(input string tag, input int exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sbq.push_back(e);
  endtask

  task automatic observe(input int obs);
    sb_t e;
    if (sbq.size() == 0) begin
      chk("sb_underflow", obs, -1);
    end else begin
      e = sbq.pop_front();
      chk(e.tag, obs, e.exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic duty(output int hl, output int hr);
    hl = 0;
    hr = 0;
    for (int i = 0; i < PWM_PERIOD; i++) begin
      step();
      hl += int'(pwmL);
      hr += int'(pwmR);
    end
  endtask

  task automatic check_duty(input string tag, input int el, input int er);
    int hl, hr;
    expect_val({tag, "_pwmL"}, el);
    expect_val({tag, "_pwmR"}, er);
    duty(hl, hr);
    observe(hl);
    observe(hr);
  endtask

  task automatic check_state(input string tag, input int n, input int exp);
    expect_val(tag, exp);
    step(n);
    observe(int'(state));
  endtask

  initial begin
    int seen;
    rst     = 1'b0;
    enable  = 1'b1;
    sensors = 3'b010;

    // reset state
    expect_val("rst_state", 0);
    expect_val("rst_dirL", 1);
    expect_val("rst_dirR", 1);
    expect_val("rst_pwm", 0);
    step(3);
    observe(int'(state));
    observe(int'(dirL));
    observe(int'(dirR));
    observe(int'({pwmL, pwmR}));
    rst = 1'b1;
    check_state("first_fwd", 1, 1);
    step();
    check_duty("fwd", DUTY_FAST, DUTY_FAST);

    // steering
    sensors = 3'b100;
    check_state("left_pre", 2, 1);
    check_state("left", 1, 2);
    expect_val("left_dirs", 3);
    observe(int'({dirL, dirR}));
    step();
    check_duty("left", DUTY_SLOW, DUTY_FAST);
    sensors = 3'b011;
    check_state("right", 3, 3);
    step();
    check_duty("right", DUTY_FAST, DUTY_SLOW);

    // lost timer: 39 cycles of no line is not enough
    sensors = 3'b010;
    check_state("back_fwd", 3, 1);
    sensors = 3'b000;
    step(39);
    sensors = 3'b010;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (state == 3'd4) seen = 1;
    end
    expect_val("no_search", 0);
    observe(seen);
    sensors = 3'b000;
    check_state("lost_pre", 42, 1);
    check_state("lost_search", 1, 4);
    expect_val("pivot_dirs", 2);
    observe(int'({dirL, dirR}));
    step();
    check_duty("pivot", DUTY_SLOW, DUTY_SLOW);
    sensors = 3'b001;
    check_state("search_exit", 3, 3);

    // halt after search timeout
    sensors = 3'b000;
    check_state("halt_search", 43, 4);
    check_state("halt_pre", 49, 4);
    check_state("halt", 1, 5);
    check_duty("halt", 0, 0);
    expect_val("halt_dirs", 3);
    observe(int'({dirL, dirR}));
    enable = 1'b0;
    check_state("halt_idle", 1, 0);
    enable = 1'b1;
    check_state("halt_fwd", 1, 1);

    // enable drop on the search-timeout edge
    check_state("prio_fwd", 40, 1);
    check_state("prio_search", 1, 4);
    check_state("prio_pre", 49, 4);
    enable = 1'b0;
    check_state("prio_idle", 1, 0);
    check_state("prio_hold", 3, 0);

    // asynchronous reset mid-operation
    enable  = 1'b1;
    sensors = 3'b010;
    check_state("run_again", 2, 1);
    rst = 1'b0;
    expect_val("async_rst", 0);
    #1;
    observe(int'(state));
    rst = 1'b1;

    if (sbq.size() != 0) chk("sb_leftover", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
